// File: rtl/pe_bank_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_bank_seq_ctrl_pkg
// Description : Shared types for the PE bank sequencer. Holds the state
//               encoding, the job descriptor and the drain-latency default.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_bank_seq_ctrl_pkg;

    localparam int DESC_K_WIDTH    = 16;
    localparam int DESC_TILE_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_e;

    // Job descriptor as latched on accept
    typedef struct packed {
        logic [DESC_K_WIDTH-1:0]    num_k;
        logic [DESC_TILE_WIDTH-1:0] num_tile;
    } job_desc_t;

    // Skewed array needs one advance per row plus one per column to empty
    function automatic int drain_lat_default(input int num_row, input int num_col);
        return num_row + num_col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_bank_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_bank_seq_ctrl_if
// Description : Handshake and control bundle around the PE bank sequencer.
//               master = the sequencer, slave = scheduler/buffers/bank/writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_bank_seq_ctrl_if #(
    parameter int K_WIDTH    = 16,
    parameter int TILE_WIDTH = 12
);
    logic                  cfg_vld;
    logic                  cfg_rdy;
    logic [K_WIDTH-1:0]    cfg_num_k;
    logic [TILE_WIDTH-1:0] cfg_num_tile;
    logic                  feed_vld;
    logic                  feed_rdy;
    logic                  bank_vld;
    logic                  bank_rdy;
    logic                  bank_acc_reset;
    logic                  fm_vld;
    logic                  fm_rdy;
    logic [TILE_WIDTH-1:0] fm_tile_idx;
    logic                  busy;
    logic                  done;

    modport master (
        input  cfg_vld, cfg_num_k, cfg_num_tile, feed_vld, fm_rdy,
        output cfg_rdy, feed_rdy, bank_vld, bank_rdy, bank_acc_reset,
               fm_vld, fm_tile_idx, busy, done
    );

    modport slave (
        output cfg_vld, cfg_num_k, cfg_num_tile, feed_vld, fm_rdy,
        input  cfg_rdy, feed_rdy, bank_vld, bank_rdy, bank_acc_reset,
               fm_vld, fm_tile_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pe_bank_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pe_bank_perf_cnt
// Description : Saturating event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_bank_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pe_bank_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_bank_seq_ctrl
// Description : Sequencer for one PE systolic bank: feeds K beats per tile,
//               flushes and drains the skewed array, then holds the bank
//               frozen while the tile result is handed to the writer.
//               Optional macro PE_BANK_SEQ_CTRL_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_bank_seq_ctrl
    import pe_bank_seq_ctrl_pkg::*;
#(
    parameter int NUM_ROW    = 16,
    parameter int NUM_COL    = 16,
    parameter int K_WIDTH    = DESC_K_WIDTH,
    parameter int TILE_WIDTH = DESC_TILE_WIDTH,
    parameter int DRAIN_LAT  = drain_lat_default(NUM_ROW, NUM_COL)
) (
    input  logic               clk,
    input  logic               rst,
    pe_bank_seq_ctrl_if.master bus
`ifdef PE_BANK_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_busy_cyc,
    output logic [31:0]        perf_feed_bubble,
    output logic [31:0]        perf_out_stall
`endif
);
    localparam int DRAIN_W = $clog2(DRAIN_LAT + 1);
    localparam logic [K_WIDTH-1:0]    C_K_ONE     = K_WIDTH'(1);
    localparam logic [TILE_WIDTH-1:0] C_T_ONE     = TILE_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]    C_D_ONE     = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0]    C_DRAIN_END = DRAIN_W'(DRAIN_LAT - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    job_desc_t             r_desc;
    logic [K_WIDTH-1:0]    r_k_cnt;
    logic [TILE_WIDTH-1:0] r_tile_cnt;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic                  r_done;

    logic w_cfg_zero;
    logic w_k_last;
    logic w_t_last;
    logic w_drain_last;

    assign w_cfg_zero   = (bus.cfg_num_k == '0) || (bus.cfg_num_tile == '0);
    // K-1 is compared before the counter could ever overflow
    assign w_k_last     = (r_k_cnt == (r_desc.num_k - C_K_ONE));
    assign w_t_last     = (r_tile_cnt == (r_desc.num_tile - C_T_ONE));
    assign w_drain_last = (r_drain_cnt == C_DRAIN_END);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and bank/handshake controls
    always_comb begin
        w_state_nxt        = r_state;
        bus.cfg_rdy        = 1'b0;
        bus.feed_rdy       = 1'b0;
        bus.bank_vld       = 1'b0;
        bus.bank_rdy       = 1'b0;
        bus.bank_acc_reset = 1'b0;
        bus.fm_vld         = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cfg_rdy = 1'b1;
                if (bus.cfg_vld && !w_cfg_zero) begin
                    w_state_nxt = FEED;
                end
            end
            FEED: begin
                // A bubble still advances the array, but injects nothing
                bus.bank_rdy       = 1'b1;
                bus.feed_rdy       = bus.feed_vld;
                bus.bank_vld       = bus.feed_vld;
                bus.bank_acc_reset = bus.feed_vld && (r_k_cnt == '0);
                if (bus.feed_vld && w_k_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                bus.bank_rdy       = 1'b1;
                bus.bank_acc_reset = 1'b1;
                w_state_nxt        = DRAIN;
            end
            DRAIN: begin
                bus.bank_rdy = 1'b1;
                if (w_drain_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                // bank_rdy stays low so out_fm is frozen until accepted
                bus.fm_vld = 1'b1;
                if (bus.fm_rdy) begin
                    w_state_nxt = w_t_last ? IDLE : FEED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Descriptor latch, beat/tile/drain counters and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc      <= '0;
            r_k_cnt     <= '0;
            r_tile_cnt  <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cfg_vld) begin
                        r_desc.num_k    <= bus.cfg_num_k;
                        r_desc.num_tile <= bus.cfg_num_tile;
                        r_k_cnt         <= '0;
                        r_tile_cnt      <= '0;
                        r_done          <= w_cfg_zero;
                    end
                end
                FEED: begin
                    if (bus.feed_vld) begin
                        r_k_cnt <= w_k_last ? '0 : (r_k_cnt + C_K_ONE);
                    end
                end
                FLUSH: begin
                    r_drain_cnt <= '0;
                end
                DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + C_D_ONE;
                end
                OUT: begin
                    if (bus.fm_rdy) begin
                        // Index returns to 0 once the whole job is delivered
                        r_tile_cnt <= w_t_last ? '0 : (r_tile_cnt + C_T_ONE);
                        r_done     <= w_t_last;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fm_tile_idx = r_tile_cnt;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;

`ifdef PE_BANK_SEQ_CTRL_PERF_EN
    logic w_job_accept;
    logic w_feed_bubble;
    logic w_out_stall;

    assign w_job_accept  = (r_state == IDLE) && bus.cfg_vld;
    assign w_feed_bubble = (r_state == FEED) && !bus.feed_vld;
    assign w_out_stall   = (r_state == OUT) && !bus.fm_rdy;

    pe_bank_perf_cnt #(.WIDTH(32)) u_perf_busy (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_job_accept),
        .inc   (bus.busy),
        .count (perf_busy_cyc)
    );

    pe_bank_perf_cnt #(.WIDTH(32)) u_perf_bubble (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_job_accept),
        .inc   (w_feed_bubble),
        .count (perf_feed_bubble)
    );

    pe_bank_perf_cnt #(.WIDTH(32)) u_perf_stall (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_job_accept),
        .inc   (w_out_stall),
        .count (perf_out_stall)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_bank_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_bank_seq_ctrl
// Description : Directed self-checking bench for pe_bank_seq_ctrl with a
//               4x4 bank (drain latency 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_bank_seq_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pe_bank_seq_ctrl_if #(.K_WIDTH(16), .TILE_WIDTH(12)) bus ();

`ifdef PE_BANK_SEQ_CTRL_PERF_EN
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_feed_bubble;
    logic [31:0] perf_out_stall;
`endif

    pe_bank_seq_ctrl #(
        .NUM_ROW    (4),
        .NUM_COL    (4),
        .K_WIDTH    (16),
        .TILE_WIDTH (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PE_BANK_SEQ_CTRL_PERF_EN
        ,
        .perf_busy_cyc    (perf_busy_cyc),
        .perf_feed_bubble (perf_feed_bubble),
        .perf_out_stall   (perf_out_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control snapshot: {bank_vld, bank_rdy, bank_acc_reset, fm_vld, busy, feed_rdy}
    logic [5:0] ctl;
    assign ctl = {bus.bank_vld, bus.bank_rdy, bus.bank_acc_reset,
                  bus.fm_vld, bus.busy, bus.feed_rdy};

    localparam logic [5:0] P_IDLE  = 6'b000000;
    localparam logic [5:0] P_FEED0 = 6'b111011;
    localparam logic [5:0] P_FEED  = 6'b110011;
    localparam logic [5:0] P_BUBL  = 6'b010010;
    localparam logic [5:0] P_FLUSH = 6'b011010;
    localparam logic [5:0] P_DRAIN = 6'b010010;
    localparam logic [5:0] P_OUT   = 6'b000110;

    // Advance to 1ns after the next rising edge (input drive point)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        total++;
        if ({bus.cfg_rdy, ctl, bus.done} !== 8'b1_000000_0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=%b", {bus.cfg_rdy, ctl, bus.done}, 8'b1_000000_0);
        end
        total++;
        if (bus.fm_tile_idx !== 12'd0) begin
            bad++;
            $display("FAIL reset_idx got=%0d want=0", bus.fm_tile_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        logic [5:0] exp;
        step();
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd3; bus.cfg_num_tile = 12'd1;
        bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
        #1;
        total++;
        if ({bus.cfg_rdy, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL single_accept got=%b want=10", {bus.cfg_rdy, bus.busy});
        end
        // Cycle i after accept: 1..3 FEED, 4 FLUSH, 5..12 DRAIN, 13 OUT, 14 IDLE
        for (int i = 1; i <= 14; i++) begin
            step();
            bus.cfg_vld = 1'b0;
            #1;
            if (i == 1)       exp = P_FEED0;
            else if (i <= 3)  exp = P_FEED;
            else if (i == 4)  exp = P_FLUSH;
            else if (i <= 12) exp = P_DRAIN;
            else if (i == 13) exp = P_OUT;
            else              exp = P_IDLE;
            total++;
            if (ctl !== exp) begin
                bad++;
                $display("FAIL single_ctl cyc=%0d got=%b want=%b", i, ctl, exp);
            end
            if (i == 13) begin
                total++;
                if (bus.fm_tile_idx !== 12'd0) begin
                    bad++;
                    $display("FAIL single_idx got=%0d want=0", bus.fm_tile_idx);
                end
            end
            if (i == 14) begin
                total++;
                if ({bus.done, bus.cfg_rdy} !== 2'b11) begin
                    bad++;
                    $display("FAIL single_done got=%b want=11", {bus.done, bus.cfg_rdy});
                end
            end
        end
        step();
        #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_width got=%b want=0", bus.done);
        end
    endtask

    task automatic test_multi_tile();
        int n_acc;
        int n_hs;
        int n_done;
        logic [11:0] idx [3];
        n_acc = 0; n_hs = 0; n_done = 0;
        for (int j = 0; j < 3; j++) idx[j] = 12'hFFF;
        step();
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd4; bus.cfg_num_tile = 12'd3;
        bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
        #1;
        // 3 tiles x (4 feed + 1 flush + 8 drain + 1 out) = 42 busy cycles
        for (int n = 0; n < 55; n++) begin
            step();
            bus.cfg_vld = 1'b0;
            #1;
            if (bus.bank_acc_reset) n_acc++;
            if (bus.fm_vld && bus.fm_rdy) begin
                if (n_hs < 3) idx[n_hs] = bus.fm_tile_idx;
                n_hs++;
            end
            if (bus.done) n_done++;
        end
        total++;
        if (n_acc != 6) begin
            bad++;
            $display("FAIL multi_acc_reset got=%0d want=6", n_acc);
        end
        total++;
        if (n_hs != 3) begin
            bad++;
            $display("FAIL multi_handshakes got=%0d want=3", n_hs);
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (idx[j] !== 12'(j)) begin
                bad++;
                $display("FAIL multi_idx%0d got=%0d want=%0d", j, idx[j], j);
            end
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL multi_done got=%0d want=1", n_done);
        end
    endtask

    task automatic test_bubble();
        logic got;
        step();
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd2; bus.cfg_num_tile = 12'd1;
        bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
        #1;
        step(); bus.cfg_vld = 1'b0; bus.feed_vld = 1'b1; #1;
        total++;
        if (ctl !== P_FEED0) begin
            bad++;
            $display("FAIL bubble_beat0 got=%b want=%b", ctl, P_FEED0);
        end
        step(); bus.feed_vld = 1'b0; #1;
        total++;
        if (ctl !== P_BUBL) begin
            bad++;
            $display("FAIL bubble_gap got=%b want=%b", ctl, P_BUBL);
        end
        step(); bus.feed_vld = 1'b1; #1;
        total++;
        if (ctl !== P_FEED) begin
            bad++;
            $display("FAIL bubble_beat1 got=%b want=%b", ctl, P_FEED);
        end
        step(); bus.feed_vld = 1'b0; #1;
        total++;
        if (ctl !== P_FLUSH) begin
            bad++;
            $display("FAIL bubble_flush got=%b want=%b", ctl, P_FLUSH);
        end
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            step(); #1;
            if (bus.done) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bubble_done_timeout got=0 want=1");
        end
    endtask

    task automatic test_out_stall();
        logic got;
        step();
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd1; bus.cfg_num_tile = 12'd2;
        bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
        #1;
        step(); bus.cfg_vld = 1'b0; #1;
        got = bus.fm_vld;
        for (int n = 0; n < 40 && !got; n++) begin
            step(); #1;
            got = bus.fm_vld;
        end
        total++;
        if (!got || bus.fm_tile_idx !== 12'd0) begin
            bad++;
            $display("FAIL stall_tile0 got_vld=%b idx=%0d want_vld=1 idx=0", got, bus.fm_tile_idx);
        end
        // Handshake for tile 0 occurs at this edge; stall tile 1
        step(); bus.fm_rdy = 1'b0; #1;
        got = bus.fm_vld;
        for (int n = 0; n < 40 && !got; n++) begin
            step(); #1;
            got = bus.fm_vld;
        end
        total++;
        if (!got || bus.fm_tile_idx !== 12'd1) begin
            bad++;
            $display("FAIL stall_tile1 got_vld=%b idx=%0d want_vld=1 idx=1", got, bus.fm_tile_idx);
        end
        for (int n = 0; n < 20; n++) begin
            step(); #1;
            total++;
            if ({bus.fm_vld, bus.bank_rdy, bus.done, bus.fm_tile_idx} !== {3'b100, 12'd1}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d vld/rdy/done=%b idx=%0d want=100 idx=1",
                         n, {bus.fm_vld, bus.bank_rdy, bus.done}, bus.fm_tile_idx);
            end
        end
        bus.fm_rdy = 1'b1;
        step(); #1;
        total++;
        if ({bus.done, bus.fm_vld, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL stall_release got=%b want=100", {bus.done, bus.fm_vld, bus.busy});
        end
    endtask

    task automatic test_zero_cfg();
        for (int c = 0; c < 2; c++) begin
            step();
            bus.cfg_vld = 1'b1; bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
            bus.cfg_num_k    = (c == 0) ? 16'd0 : 16'd5;
            bus.cfg_num_tile = (c == 0) ? 12'd5 : 12'd0;
            #1;
            step(); bus.cfg_vld = 1'b0; #1;
            total++;
            if ({bus.done, bus.cfg_rdy, ctl} !== {2'b11, P_IDLE}) begin
                bad++;
                $display("FAIL zero_done case=%0d got=%b want=%b", c, {bus.done, bus.cfg_rdy, ctl}, {2'b11, P_IDLE});
            end
            for (int n = 0; n < 3; n++) begin
                step(); #1;
                total++;
                if ({bus.done, ctl} !== {1'b0, P_IDLE}) begin
                    bad++;
                    $display("FAIL zero_idle case=%0d cyc=%0d got=%b want=%b", c, n, {bus.done, ctl}, {1'b0, P_IDLE});
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        logic got;
        step();
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd2; bus.cfg_num_tile = 12'd1;
        bus.feed_vld = 1'b1; bus.fm_rdy = 1'b1;
        #1;
        // Cycles 1-2 FEED, 3 FLUSH, 4 DRAIN, 5 DRAIN
        for (int i = 1; i <= 5; i++) begin
            step(); bus.cfg_vld = 1'b0; #1;
        end
        total++;
        if (ctl !== P_DRAIN) begin
            bad++;
            $display("FAIL rstmid_in_drain got=%b want=%b", ctl, P_DRAIN);
        end
        rst = 1'b1;
        step(); #1;
        total++;
        if ({bus.cfg_rdy, ctl, bus.done, bus.fm_tile_idx} !== {1'b1, P_IDLE, 1'b0, 12'd0}) begin
            bad++;
            $display("FAIL rstmid_values got=%b want=%b",
                     {bus.cfg_rdy, ctl, bus.done, bus.fm_tile_idx}, {1'b1, P_IDLE, 1'b0, 12'd0});
        end
        rst = 1'b0;
        bus.cfg_vld = 1'b1; bus.cfg_num_k = 16'd1; bus.cfg_num_tile = 12'd1;
        step(); bus.cfg_vld = 1'b0; #1;
        total++;
        if ({ctl, bus.done} !== {P_FEED0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_new_job got=%b want=%b", {ctl, bus.done}, {P_FEED0, 1'b0});
        end
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            step(); #1;
            if (bus.done) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rstmid_done_timeout got=0 want=1");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.cfg_vld      = 1'b0;
        bus.cfg_num_k    = '0;
        bus.cfg_num_tile = '0;
        bus.feed_vld     = 1'b0;
        bus.fm_rdy       = 1'b0;
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_bubble();
        test_out_stall();
        test_zero_cfg();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
